// File: rtl/tc1_timer_ctrl.sv
// tc1_timer_ctrl: 24-bit programmable down-counting timer for the tc1 channel,
// controlled over a zero-wait-state Avalon-MM slave.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   address[1:0]     0 LOAD, 1 CTRL, 2 STATUS, 3 COUNT
//   write, writedata single-cycle register write
//   read, readdata   registered read, one clock latency, holds when read=0
//   status_word      {TO, count}, straight from registers
//   irq              TO & IRQEN, level
//
// state  | meaning
// IDLE   | count holds, prescaler parked at 0
// RUN    | prescaler cycling, count decrements on each tick
module tc1_timer_ctrl #(
    parameter int CNT_W = 24,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic [CNT_W:0]   status_word,
    output logic             irq
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] A_LOAD   = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_COUNT  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pcnt_q, pcnt_d;
    logic             cont_q, cont_d;
    logic             irqen_q, irqen_d;
    logic             to_q, to_d;
    logic [31:0]      readdata_q, readdata_d;

    logic wr_load, wr_ctrl, wr_stat, start, stop, tick;

    assign wr_load = write && (address == A_LOAD);
    assign wr_ctrl = write && (address == A_CTRL);
    assign wr_stat = write && (address == A_STATUS);
    assign start   = wr_ctrl && writedata[0];
    assign stop    = wr_ctrl && writedata[1];
    assign tick    = (state_q == S_RUN) && (pcnt_q == pre_q);

    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        count_d    = count_q;
        pre_d      = pre_q;
        pcnt_d     = pcnt_q;
        cont_d     = cont_q;
        irqen_d    = irqen_q;
        to_d       = to_q;
        readdata_d = readdata_q;

        if (wr_load) begin
            load_d = writedata[CNT_W-1:0];
        end
        if (wr_ctrl) begin
            cont_d  = writedata[2];
            irqen_d = writedata[3];
            pre_d   = writedata[8 +: PRE_W];
        end
        if (wr_stat) begin
            to_d = 1'b0;
        end

        // STOP beats START; both beat the prescaler tick in the same cycle.
        if (stop) begin
            state_d = S_IDLE;
            pcnt_d  = '0;
        end else if (start) begin
            state_d = S_RUN;
            count_d = load_q;
            pcnt_d  = '0;
        end else if (state_q == S_RUN) begin
            if (tick) begin
                pcnt_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    // Placed after the STATUS clear so a coincident set wins.
                    to_d = 1'b1;
                    if (cont_q) begin
                        count_d = load_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end else begin
                // Free wrap lets pcnt come back around when P is lowered below it.
                pcnt_d = pcnt_q + PRE_ONE;
            end
        end

        if (read) begin
            readdata_d = '0;
            case (address)
                A_LOAD:   readdata_d[CNT_W-1:0] = load_q;
                A_CTRL: begin
                    readdata_d[0]          = (state_q == S_RUN);
                    readdata_d[2]          = cont_q;
                    readdata_d[3]          = irqen_q;
                    readdata_d[8 +: PRE_W] = pre_q;
                end
                A_STATUS: begin
                    readdata_d[0] = to_q;
                    readdata_d[1] = (state_q == S_RUN);
                end
                default:  readdata_d[CNT_W-1:0] = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            load_q     <= '0;
            count_q    <= '0;
            pre_q      <= '0;
            pcnt_q     <= '0;
            cont_q     <= 1'b0;
            irqen_q    <= 1'b0;
            to_q       <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            pcnt_q     <= pcnt_d;
            cont_q     <= cont_d;
            irqen_q    <= irqen_d;
            to_q       <= to_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata    = readdata_q;
    assign status_word = {to_q, count_q};
    assign irq         = to_q & irqen_q;

endmodule

// File: tb/tb_tc1_timer_ctrl.sv
module tb_tc1_timer_ctrl;

    localparam int CNT_W = 24;
    localparam int PRE_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address = 2'd0;
    logic             write = 1'b0;
    logic [31:0]      writedata = 32'd0;
    logic             read = 1'b0;
    logic [31:0]      readdata;
    logic [CNT_W:0]   status_word;
    logic             irq;

    tc1_timer_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .write(write),
        .writedata(writedata),
        .read(read),
        .readdata(readdata),
        .status_word(status_word),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural reference: plain integers stepped once per clock.
    bit          m_run, m_to, m_cont, m_irqen;
    int unsigned m_load, m_count, m_pcnt, m_p;
    logic [31:0] m_rd;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_to = 0; m_cont = 0; m_irqen = 0;
        m_load = 0; m_count = 0; m_pcnt = 0; m_p = 0; m_rd = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [1:0] a, input logic [31:0] d);
        bit set_to;
        bit start;
        bit stop;
        set_to = 0;
        if (r) begin
            case (a)
                2'd0: m_rd = m_load;
                2'd1: m_rd = (m_p << 8) | (32'(m_irqen) << 3) | (32'(m_cont) << 2) | 32'(m_run);
                2'd2: m_rd = (32'(m_run) << 1) | 32'(m_to);
                default: m_rd = m_count;
            endcase
        end
        start = w && a == 2'd1 && d[0];
        stop  = w && a == 2'd1 && d[1];
        if (stop) begin
            m_run = 0; m_pcnt = 0;
        end else if (start) begin
            m_run = 1; m_count = m_load; m_pcnt = 0;
        end else if (m_run) begin
            if (m_pcnt == m_p) begin
                m_pcnt = 0;
                if (m_count > 0) m_count = m_count - 1;
                else begin
                    set_to = 1;
                    if (m_cont) m_count = m_load;
                    else m_run = 0;
                end
            end else begin
                m_pcnt = (m_pcnt + 1) % 256;
            end
        end
        if (w && a == 2'd0) m_load = d % (1 << 24);
        if (w && a == 2'd1) begin
            m_cont = d[2]; m_irqen = d[3]; m_p = 32'(d[15:8]);
        end
        if (set_to) m_to = 1;
        else if (w && a == 2'd2) m_to = 0;
    endtask

    task automatic bus(input bit w, input bit r, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        write = w; read = r; address = a; writedata = d;
        @(posedge clk);
        model_step(w, r, a, d);
        #1;
        check_val("status_word", 64'(status_word), (64'(m_to) << 24) | 64'(m_count));
        check_val("irq", 64'(irq), 64'(m_to & m_irqen));
        check_val("readdata", 64'(readdata), 64'(m_rd));
    endtask

    task automatic idle();            bus(0, 0, 2'd0, 32'd0); endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d); bus(1, 0, a, d); endtask
    task automatic rd(input logic [1:0] a); bus(0, 1, a, 32'd0); endtask

    // Counts edges from the current point until TO is seen; bounded.
    task automatic wait_to(input string tag, input int exp);
        int n;
        n = 0;
        while (!status_word[CNT_W] && n < 300) begin
            idle();
            n++;
        end
        check_val(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        model_reset();
        #3;
        check_val("rst_readdata", 64'(readdata), 64'd0);
        check_val("rst_status", 64'(status_word), 64'd0);
        check_val("rst_irq", 64'(irq), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // One-shot, P=0
        wr(2'd0, 32'd5);
        wr(2'd1, 32'h0001);
        wait_to("oneshot_to", 6);
        idle(); idle();
        rd(2'd2);
        check_val("oneshot_stat", 64'(readdata), 64'h1);
        check_val("oneshot_cnt", 64'(status_word[CNT_W-1:0]), 64'd0);

        // Prescale + continuous, period 16
        wr(2'd2, 32'd0);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'h0305);
        wait_to("cont_to1", 16);
        wr(2'd2, 32'hDEAD);
        wait_to("cont_to2", 15);

        // IRQ enable with clear colliding with TO set
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h030D);
        for (int i = 0; i < 100; i++) begin
            if (m_run && m_pcnt == m_p && m_count == 0) break;
            idle();
        end
        wr(2'd2, 32'd0);
        check_val("coll_to", 64'(status_word[CNT_W]), 64'd1);
        check_val("coll_irq", 64'(irq), 64'd1);
        wr(2'd2, 32'd0);
        check_val("clr_irq", 64'(irq), 64'd0);

        // STOP+START together: STOP wins
        idle(); idle(); idle();
        wr(2'd1, 32'h0003);
        idle(); idle(); idle(); idle();
        rd(2'd2);
        check_val("stop_run", 64'(readdata[1]), 64'd0);

        // LOAD=0 with P=2
        wr(2'd0, 32'd0);
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h0201);
        wait_to("load0_to", 3);

        // Read path
        wr(2'd0, 32'h00FF_FFFF);
        wr(2'd1, 32'h0001);
        idle(); idle();
        rd(2'd3);
        check_val("rd_hi", 64'(readdata[31:24]), 64'd0);
        check_val("rd_cnt", 64'(readdata), 64'h00FF_FFFD);

        // IRQEN set while TO=1
        wr(2'd1, 32'h0008);
        check_val("irqen_late", 64'(irq), 64'(m_to));

        // Reset mid-run
        wr(2'd0, 32'd40);
        wr(2'd1, 32'h010D);
        idle(); idle(); idle(); rd(2'd3);
        @(negedge clk);
        reset_n = 1'b0;
        write = 0; read = 0;
        #1;
        check_val("mid_rst_readdata", 64'(readdata), 64'd0);
        check_val("mid_rst_status", 64'(status_word), 64'd0);
        check_val("mid_rst_irq", 64'(irq), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(); idle();
        rd(2'd3);
        check_val("post_rst_cnt", 64'(readdata), 64'd0);
        rd(2'd1);
        check_val("post_rst_run", 64'(readdata[0]), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int sel;
            logic [31:0] d;
            logic [1:0]  a;
            sel = $urandom_range(0, 99);
            a = 2'($urandom_range(0, 3));
            if (sel < 6) begin
                bus(1, $urandom_range(0, 1), 2'd0, 32'($urandom_range(0, 12)) | ($urandom() & 32'hFF00_0000));
            end else if (sel < 12) begin
                d = $urandom() & 32'hFFFF_00FF;
                d[1] = ($urandom_range(0, 7) == 0);
                d[0] = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 9) == 0) d[15:8] = 8'($urandom_range(0, 255));
                else d[15:8] = 8'($urandom_range(0, 3));
                bus(1, $urandom_range(0, 1), 2'd1, d);
            end else if (sel < 16) begin
                bus(1, $urandom_range(0, 1), 2'd2, $urandom());
            end else begin
                bus(0, $urandom_range(0, 1), a, $urandom());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
